// File: rtl/p4_arb_pkg.sv
// Shared types and constants for the packet-level P4 stream arbiter.
// The optional source tag (P4_ARB_SRC_TAG_EN) uses the metadata MSB.
package p4_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1
  } arb_state_e;

  // Default source-tag position for 48-bit metadata; the module uses META_W-1.
  localparam int unsigned SRC_TAG_BIT = 47;
  localparam int unsigned CNT_W       = 32;

endpackage

// File: rtl/p4_stream_arbiter.sv
// Two-source packet round-robin arbiter in front of a P4 pipeline s_axis port.
// Define P4_ARB_SRC_TAG_EN to stamp the granted source ID into user_metadata_out[META_W-1].
module p4_stream_arbiter
  import p4_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned META_W = 48
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tvalid,
  input  logic [META_W-1:0] s0_axis_tuser,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tvalid,
  input  logic [META_W-1:0] s1_axis_tuser,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [META_W-1:0] user_metadata_out,
  output logic              user_metadata_out_valid,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  arb_state_e       state_q, state_d;
  logic             last_src_q, last_src_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // On a tie the source that did not send the previous packet wins.
  function automatic arb_state_e pick_grant(input logic v0, input logic v1, input logic last);
    arb_state_e nxt;
    if (v0 && v1) begin
      nxt = last ? StGnt0 : StGnt1;
    end else if (v0) begin
      nxt = StGnt0;
    end else if (v1) begin
      nxt = StGnt1;
    end else begin
      nxt = StIdle;
    end
    return nxt;
  endfunction

  always_comb begin
    state_d           = state_q;
    last_src_d        = last_src_q;
    pkt_cnt0_d        = pkt_cnt0_q;
    pkt_cnt1_d        = pkt_cnt1_q;
    m_axis_tdata      = '0;
    m_axis_tkeep      = s0_axis_tkeep;
    m_axis_tlast      = s0_axis_tlast;
    m_axis_tvalid     = 1'b0;
    s0_axis_tready    = 1'b0;
    s1_axis_tready    = 1'b0;
    user_metadata_out = '0;

    unique case (state_q)
      StIdle: begin
        state_d = pick_grant(s0_axis_tvalid, s1_axis_tvalid, last_src_q);
      end
      StGnt0: begin
        m_axis_tdata      = s0_axis_tdata;
        m_axis_tkeep      = s0_axis_tkeep;
        m_axis_tlast      = s0_axis_tlast;
        m_axis_tvalid     = s0_axis_tvalid;
        s0_axis_tready    = m_axis_tready;
        user_metadata_out = s0_axis_tuser;
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
          last_src_d = 1'b0;
          pkt_cnt0_d = pkt_cnt0_q + CntOne;
          state_d    = pick_grant(s0_axis_tvalid, s1_axis_tvalid, 1'b0);
        end
      end
      StGnt1: begin
        m_axis_tdata      = s1_axis_tdata;
        m_axis_tkeep      = s1_axis_tkeep;
        m_axis_tlast      = s1_axis_tlast;
        m_axis_tvalid     = s1_axis_tvalid;
        s1_axis_tready    = m_axis_tready;
        user_metadata_out = s1_axis_tuser;
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
          last_src_d = 1'b1;
          pkt_cnt1_d = pkt_cnt1_q + CntOne;
          state_d    = pick_grant(s0_axis_tvalid, s1_axis_tvalid, 1'b1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef P4_ARB_SRC_TAG_EN
    if (state_q != StIdle) begin
      user_metadata_out[META_W-1] = (state_q == StGnt1);
    end
`endif
  end

  assign user_metadata_out_valid = m_axis_tvalid;
  assign pkt_cnt0                = pkt_cnt0_q;
  assign pkt_cnt1                = pkt_cnt1_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      last_src_q <= 1'b1;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

endmodule

// File: tb/tb_p4_stream_arbiter.sv
// Randomized bench for p4_stream_arbiter against a packet-ownership reference model.
// Honours P4_ARB_SRC_TAG_EN when predicting user_metadata_out.
module tb_p4_stream_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned MW = 48;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] in_d [2];
  logic [KW-1:0] in_k [2];
  logic          in_l [2];
  logic          in_v [2];
  logic [MW-1:0] in_u [2];
  logic          s0_rdy, s1_rdy;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last, m_valid, m_ready;
  logic [MW-1:0] meta;
  logic          meta_valid;
  logic [31:0]   cnt0, cnt1;

  always #5 aclk = ~aclk;

  p4_stream_arbiter #(
    .DATA_W(DW),
    .KEEP_W(KW),
    .META_W(MW)
  ) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s0_axis_tdata          (in_d[0]),
    .s0_axis_tkeep          (in_k[0]),
    .s0_axis_tlast          (in_l[0]),
    .s0_axis_tvalid         (in_v[0]),
    .s0_axis_tuser          (in_u[0]),
    .s0_axis_tready         (s0_rdy),
    .s1_axis_tdata          (in_d[1]),
    .s1_axis_tkeep          (in_k[1]),
    .s1_axis_tlast          (in_l[1]),
    .s1_axis_tvalid         (in_v[1]),
    .s1_axis_tuser          (in_u[1]),
    .s1_axis_tready         (s1_rdy),
    .m_axis_tdata           (m_data),
    .m_axis_tkeep           (m_keep),
    .m_axis_tlast           (m_last),
    .m_axis_tvalid          (m_valid),
    .m_axis_tready          (m_ready),
    .user_metadata_out      (meta),
    .user_metadata_out_valid(meta_valid),
    .pkt_cnt0               (cnt0),
    .pkt_cnt1               (cnt1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which source owns the output, who sent last, packets seen.
  int          owner;
  bit          last_m;
  logic [31:0] cnt_m [2];

  // Source drivers: beat currently offered, beats left in packet, beat index, packet id.
  bit pend [2];
  int left [2];
  int bidx [2];
  int pid  [2];

  function automatic int pick(input bit a, input bit b, input bit lst);
    if (a && b) return lst ? 0 : 1;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner  = -1;
    last_m = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = '0;
      pend[i]  = 1'b0;
      left[i]  = 0;
    end
  endtask

  task automatic step(input int p0, input int p1, input int pr, input bit rst);
    int          prob [2];
    bit          e_rdy [2];
    bit          hs [2];
    logic [DW-1:0] e_data;
    logic [MW-1:0] e_meta;
    bit          e_valid;
    int          nxt;
    prob[0] = p0;
    prob[1] = p1;
    @(negedge aclk);
    aresetn = !rst;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(99) < prob[i]) begin
        if (left[i] == 0) begin
          left[i] = $urandom_range(4, 1);
          bidx[i] = 0;
          pid[i]++;
          in_u[i] = {$urandom(), $urandom()};
        end
        pend[i] = 1'b1;
        in_d[i] = {8'(i), 8'(pid[i]), 8'(bidx[i]), 8'h00, $urandom()};
        in_k[i] = 8'($urandom());
        in_l[i] = (left[i] == 1);
      end else if (!pend[i]) begin
        in_d[i] = {$urandom(), $urandom()};
      end
      in_v[i] = pend[i];
    end
    m_ready = ($urandom_range(99) < pr);
    #1;
    e_rdy[0] = (owner == 0) && m_ready;
    e_rdy[1] = (owner == 1) && m_ready;
    e_valid  = (owner >= 0) && in_v[owner];
    e_data   = (owner >= 0) ? in_d[owner] : '0;
    e_meta   = (owner >= 0) ? in_u[owner] : '0;
`ifdef P4_ARB_SRC_TAG_EN
    if (owner >= 0) e_meta[MW-1] = owner[0];
`endif
    check("m_tvalid", m_valid, e_valid);
    check("meta_valid", meta_valid, e_valid);
    check("s0_tready", s0_rdy, e_rdy[0]);
    check("s1_tready", s1_rdy, e_rdy[1]);
    check("m_tdata", m_data, e_data);
    check("meta", meta, e_meta);
    check("pkt_cnt0", cnt0, cnt_m[0]);
    check("pkt_cnt1", cnt1, cnt_m[1]);
    if (owner >= 0) begin
      check("m_tkeep", m_keep, in_k[owner]);
      check("m_tlast", m_last, in_l[owner]);
    end
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) hs[i] = in_v[i] && e_rdy[i];
      if (owner < 0) begin
        owner = pick(in_v[0], in_v[1], last_m);
      end else if (hs[owner] && in_l[owner]) begin
        cnt_m[owner] = cnt_m[owner] + 32'd1;
        last_m       = owner[0];
        nxt          = pick(in_v[0], in_v[1], owner[0]);
        owner        = nxt;
      end
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          pend[i] = 1'b0;
          left[i]--;
          bidx[i]++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_d[i] = '0;
      in_k[i] = '0;
      in_l[i] = 1'b0;
      in_v[i] = 1'b0;
      in_u[i] = '0;
      pid[i]  = 0;
      bidx[i] = 0;
    end
    m_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge aclk);

    // Reset values, then s0 alone with a ready sink.
    step(0, 0, 100, 1'b1);
    repeat (12) step(100, 0, 100, 1'b0);

    // Both sources saturated: strict alternation with no idle gap.
    step(0, 0, 100, 1'b1);
    repeat (40) step(100, 100, 100, 1'b0);

    // Backpressure from the pipeline while both sources compete.
    repeat (60) step(100, 100, 50, 1'b0);

    // General random traffic with occasional resets.
    repeat (500) step(60, 60, 70, ($urandom_range(199) == 0));

    // Reset in the middle of an s0 packet, then resume.
    step(0, 0, 100, 1'b1);
    repeat (2) step(100, 0, 100, 1'b0);
    step(100, 0, 100, 1'b1);
    repeat (12) step(100, 0, 100, 1'b0);

    // Counter wrap on source 1.
    step(0, 0, 100, 1'b1);
    force dut.pkt_cnt1_q = 32'hFFFF_FFFF;
    cnt_m[1] = 32'hFFFF_FFFF;
    step(0, 0, 100, 1'b0);
    release dut.pkt_cnt1_q;
    repeat (16) step(0, 100, 100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
